// File: rtl/branch_ctrl_if.sv
// Bus bundle for branch_ctrl: decode request, comparator drive, fetch redirect and retire pulses.
// slave = the controller, master = the surrounding pipeline (decode, comparator, fetch).
interface branch_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_kind;
    logic [2:0]  req_fun3;
    logic [31:0] req_pc;
    logic [31:0] req_imm;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic        cmp_enb;
    logic [2:0]  cmp_fun3;
    logic [31:0] cmp_a;
    logic [31:0] cmp_b;
    logic        cmp_res;
    logic        redir_valid;
    logic        redir_ready;
    logic [31:0] redir_pc;
    logic        flush;
    logic        link_valid;
    logic [31:0] link_data;
    logic        done;
    logic        taken;
    logic        err;

    modport slave (
        input  req_valid, req_kind, req_fun3, req_pc, req_imm, req_rs1, req_rs2,
        input  cmp_res, redir_ready,
        output req_ready, cmp_enb, cmp_fun3, cmp_a, cmp_b,
        output redir_valid, redir_pc, flush, link_valid, link_data, done, taken, err
    );

    modport master (
        output req_valid, req_kind, req_fun3, req_pc, req_imm, req_rs1, req_rs2,
        output cmp_res, redir_ready,
        input  req_ready, cmp_enb, cmp_fun3, cmp_a, cmp_b,
        input  redir_valid, redir_pc, flush, link_valid, link_data, done, taken, err
    );
endinterface

// File: rtl/branch_ctrl.sv
// RV32I execute-stage control-flow sequencer: comparator drive, redirect handshake, timed flush.
// Optional macro BR_PERF_CNT_EN adds saturating br_cnt/taken_cnt performance counters.
module branch_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic clk,
    input  logic rst_n,
    branch_ctrl_if.slave bus
`ifdef BR_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] taken_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CMP   = 2'd1,
        S_REDIR = 2'd2,
        S_FLUSH = 2'd3
    } state_e;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

    if (FLUSH_CYCLES < 0 || FLUSH_CYCLES > 15 || CNT_W < 1) begin : g_bad_cfg
        $error("branch_ctrl: FLUSH_CYCLES must be 0..15 and CNT_W at least 1");
    end

    function automatic logic fun3_illegal(input logic [2:0] f);
        return (f[2:1] == 2'b01);
    endfunction

    state_e      state_q, state_d;
    logic        req_ready_q, req_ready_d;
    logic        cmp_enb_q, cmp_enb_d;
    logic [2:0]  cmp_fun3_q, cmp_fun3_d;
    logic [31:0] cmp_a_q, cmp_a_d, cmp_b_q, cmp_b_d;
    logic        redir_valid_q, redir_valid_d;
    logic [31:0] redir_pc_q, redir_pc_d;
    logic        flush_q, flush_d;
    logic [3:0]  fcnt_q, fcnt_d;
    logic        link_valid_q, link_valid_d;
    logic [31:0] link_data_q, link_data_d;
    logic        done_q, done_d, taken_q, taken_d, err_q, err_d;
    logic [31:0] br_tgt_s, jalr_sum_s, jmp_tgt_s;

    assign br_tgt_s   = bus.req_pc + bus.req_imm;
    assign jalr_sum_s = bus.req_rs1 + bus.req_imm;
    assign jmp_tgt_s  = (bus.req_kind == 2'b10) ? {jalr_sum_s[31:1], 1'b0} : br_tgt_s;

    // Next-state and registered-output computation; pulses default low, captures hold.
    always_comb begin
        state_d       = state_q;
        cmp_enb_d     = 1'b0;
        cmp_fun3_d    = 3'b000;
        cmp_a_d       = 32'h0000_0000;
        cmp_b_d       = 32'h0000_0000;
        redir_valid_d = 1'b0;
        redir_pc_d    = redir_pc_q;
        flush_d       = 1'b0;
        fcnt_d        = fcnt_q;
        link_valid_d  = 1'b0;
        link_data_d   = link_data_q;
        done_d        = 1'b0;
        taken_d       = 1'b0;
        err_d         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    case (bus.req_kind)
                        2'b00: begin
                            state_d    = S_CMP;
                            cmp_enb_d  = 1'b1;
                            cmp_fun3_d = bus.req_fun3;
                            cmp_a_d    = bus.req_rs1;
                            cmp_b_d    = bus.req_rs2;
                            redir_pc_d = br_tgt_s;
                        end
                        2'b01, 2'b10: begin
                            if (jmp_tgt_s[1]) begin
                                err_d  = 1'b1;
                                done_d = 1'b1;
                            end else begin
                                state_d       = S_REDIR;
                                redir_valid_d = 1'b1;
                                redir_pc_d    = jmp_tgt_s;
                                link_valid_d  = 1'b1;
                                link_data_d   = bus.req_pc + 32'd4;
                            end
                        end
                        default: begin
                            err_d  = 1'b1;
                            done_d = 1'b1;
                        end
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CMP: begin
                // Misalignment only matters once the branch is known to be taken.
                if (fun3_illegal(cmp_fun3_q)) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (!bus.cmp_res) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (redir_pc_q[1]) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    redir_valid_d = 1'b1;
                    state_d       = S_REDIR;
                end
            end
            S_REDIR: begin
                if (bus.redir_ready) begin
                    done_d  = 1'b1;
                    taken_d = 1'b1;
                    if (FLUSH_LOAD == 4'd0) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_FLUSH;
                        flush_d = 1'b1;
                        fcnt_d  = FLUSH_LOAD;
                    end
                end else begin
                    redir_valid_d = 1'b1;
                end
            end
            S_FLUSH: begin
                if (fcnt_q <= 4'd1) begin
                    fcnt_d  = 4'd0;
                    state_d = S_IDLE;
                end else begin
                    fcnt_d  = fcnt_q - 4'd1;
                    flush_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        req_ready_d = (state_d == S_IDLE);
    end

    // State and output registers; reset drops any redirect or flush in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            req_ready_q   <= 1'b1;
            cmp_enb_q     <= 1'b0;
            cmp_fun3_q    <= 3'b000;
            cmp_a_q       <= 32'h0000_0000;
            cmp_b_q       <= 32'h0000_0000;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= 32'h0000_0000;
            flush_q       <= 1'b0;
            fcnt_q        <= 4'd0;
            link_valid_q  <= 1'b0;
            link_data_q   <= 32'h0000_0000;
            done_q        <= 1'b0;
            taken_q       <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_ready_q   <= req_ready_d;
            cmp_enb_q     <= cmp_enb_d;
            cmp_fun3_q    <= cmp_fun3_d;
            cmp_a_q       <= cmp_a_d;
            cmp_b_q       <= cmp_b_d;
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
            flush_q       <= flush_d;
            fcnt_q        <= fcnt_d;
            link_valid_q  <= link_valid_d;
            link_data_q   <= link_data_d;
            done_q        <= done_d;
            taken_q       <= taken_d;
            err_q         <= err_d;
        end
    end

    assign bus.req_ready   = req_ready_q;
    assign bus.cmp_enb     = cmp_enb_q;
    assign bus.cmp_fun3    = cmp_fun3_q;
    assign bus.cmp_a       = cmp_a_q;
    assign bus.cmp_b       = cmp_b_q;
    assign bus.redir_valid = redir_valid_q;
    assign bus.redir_pc    = redir_pc_q;
    assign bus.flush       = flush_q;
    assign bus.link_valid  = link_valid_q;
    assign bus.link_data   = link_data_q;
    assign bus.done        = done_q;
    assign bus.taken       = taken_q;
    assign bus.err         = err_q;

`ifdef BR_PERF_CNT_EN
    logic             is_br_q, is_br_d;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d, taken_cnt_q, taken_cnt_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Counter next-state: each bump is registered alongside the done pulse it counts.
    always_comb begin
        is_br_d     = is_br_q;
        br_cnt_d    = br_cnt_q;
        taken_cnt_d = taken_cnt_q;
        if (state_q == S_IDLE && bus.req_valid) begin
            is_br_d = (bus.req_kind == 2'b00);
        end else begin
            is_br_d = is_br_q;
        end
        if (done_d && (state_q == S_CMP || (state_q == S_REDIR && is_br_q))) begin
            br_cnt_d = sat_inc(br_cnt_q);
        end else begin
            br_cnt_d = br_cnt_q;
        end
        if (done_d && taken_d) begin
            taken_cnt_d = sat_inc(taken_cnt_q);
        end else begin
            taken_cnt_d = taken_cnt_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_br_q     <= 1'b0;
            br_cnt_q    <= '0;
            taken_cnt_q <= '0;
        end else begin
            is_br_q     <= is_br_d;
            br_cnt_q    <= br_cnt_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    assign br_cnt    = br_cnt_q;
    assign taken_cnt = taken_cnt_q;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: directed plan cases, reset-mid-op cases and random ops
// checked against a cycle-timeline reference model computed from the op's architectural result.
module tb_branch_ctrl;
    localparam int FC = 2;
`ifdef BR_PERF_CNT_EN
    localparam int CW = 2;
    logic [CW-1:0] br_cnt, taken_cnt;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    branch_ctrl_if bus ();

    branch_ctrl #(
        .FLUSH_CYCLES(FC)
`ifdef BR_PERF_CNT_EN
        , .CNT_W(CW)
`endif
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
`ifdef BR_PERF_CNT_EN
        , .br_cnt(br_cnt)
        , .taken_cnt(taken_cnt)
`endif
    );

    // RV32I branch condition; illegal encodings answer 1 so a misused result would show.
    function automatic logic ref_cond(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        case (f)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return $signed(a) < $signed(b);
            3'd5:    return $signed(a) >= $signed(b);
            3'd6:    return a < b;
            3'd7:    return a >= b;
            default: return 1'b1;
        endcase
    endfunction

    always_comb bus.cmp_res = ref_cond(bus.cmp_fun3, bus.cmp_a, bus.cmp_b);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_ctl"}, 32'({bus.req_ready, bus.cmp_enb, bus.cmp_fun3, bus.redir_valid, bus.flush,
                                bus.link_valid, bus.done, bus.taken, bus.err}), 32'h0000_0400);
        chk({tag, "_data"}, bus.cmp_a | bus.cmp_b | bus.redir_pc | bus.link_data, 32'h0000_0000);
    endtask

    task automatic drive_req(input logic [1:0] kind, input logic [2:0] f3, input logic [31:0] pc,
                             input logic [31:0] imm, input logic [31:0] rs1, input logic [31:0] rs2);
        bus.req_valid = 1'b1;
        bus.req_kind  = kind;
        bus.req_fun3  = f3;
        bus.req_pc    = pc;
        bus.req_imm   = imm;
        bus.req_rs1   = rs1;
        bus.req_rs2   = rs2;
    endtask

    // Issue one op and compare its whole observed timeline against the model's timeline.
    task automatic run_op(input string tag, input logic [1:0] kind, input logic [2:0] f3,
                          input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] rs1,
                          input logic [31:0] rs2, input int stall);
        int e_done, e_rdy, e_valid, e_link, e_flush, e_cmp, w;
        logic e_err, e_taken;
        logic [31:0] e_tgt;
        int n_done = 0, n_err = 0, n_link = 0, n_cmp = 0, n_valid = 0, n_flush = 0;
        int cmp_bad = 0, pc_bad = 0, wait_cyc = 0;
        int o_done = -1, o_link = -1, o_cmp = -1, o_valid = -1, o_flush = -1, o_rdy = -1;
        logic o_taken = 1'b0, o_err = 1'b0;
        logic [31:0] o_link_data = 32'h0;

        e_valid = -1; e_link = -1; e_flush = -1; e_cmp = 0;
        e_err = 1'b0; e_taken = 1'b0; e_tgt = 32'h0;
        if (kind == 2'b11) begin
            e_err = 1'b1; e_done = 1;
        end else if (kind == 2'b00) begin
            e_cmp = 1; e_tgt = pc + imm; e_done = 2;
            if (f3 == 3'd2 || f3 == 3'd3) e_err = 1'b1;
            else if (!ref_cond(f3, rs1, rs2)) e_err = 1'b0;
            else if (e_tgt[1]) e_err = 1'b1;
            else e_valid = 2;
        end else begin
            e_tgt = (kind == 2'b01) ? pc + imm : ((rs1 + imm) & 32'hFFFF_FFFE);
            e_done = 1;
            if (e_tgt[1]) e_err = 1'b1;
            else begin e_link = 1; e_valid = 1; end
        end
        e_rdy = e_done;
        if (e_valid >= 0) begin
            e_done  = e_valid + stall + 1;
            e_taken = 1'b1;
            e_flush = (FC > 0) ? e_done : -1;
            e_rdy   = e_done + FC;
        end
        w = e_rdy + 3;

        while (!bus.req_ready && wait_cyc < 50) begin
            @(posedge clk); #1;
            wait_cyc++;
        end
        chk({tag, ":ready_before"}, 32'(bus.req_ready), 32'd1);
        drive_req(kind, f3, pc, imm, rs1, rs2);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        for (int k = 1; k <= w; k++) begin
            if (bus.done) begin
                n_done++;
                if (o_done < 0) begin o_done = k; o_taken = bus.taken; o_err = bus.err; end
            end
            if (bus.err) n_err++;
            if (bus.link_valid) begin n_link++; o_link = k; o_link_data = bus.link_data; end
            if (bus.cmp_enb) begin
                n_cmp++; o_cmp = k;
                if (bus.cmp_a !== rs1 || bus.cmp_b !== rs2 || bus.cmp_fun3 !== f3) cmp_bad++;
            end else if ((bus.cmp_a | bus.cmp_b) !== 32'h0 || bus.cmp_fun3 !== 3'd0) begin
                cmp_bad++;
            end
            if (bus.redir_valid) begin
                n_valid++;
                if (o_valid < 0) o_valid = k;
                if (bus.redir_pc !== e_tgt) pc_bad++;
            end
            if (bus.flush) begin n_flush++; if (o_flush < 0) o_flush = k; end
            if (bus.req_ready && o_rdy < 0) o_rdy = k;
            bus.redir_ready = (bus.redir_valid && (k - o_valid) >= stall) ? 1'b1 : 1'b0;
            @(posedge clk); #1;
        end
        bus.redir_ready = 1'b0;

        chk({tag, ":done_cycle"}, 32'(o_done), 32'(e_done));
        chk({tag, ":done_count"}, 32'(n_done), 32'd1);
        chk({tag, ":taken"}, 32'(o_taken), 32'(e_taken));
        chk({tag, ":err_at_done"}, 32'(o_err), 32'(e_err));
        chk({tag, ":err_count"}, 32'(n_err), e_err ? 32'd1 : 32'd0);
        chk({tag, ":link_count"}, 32'(n_link), (e_link >= 0) ? 32'd1 : 32'd0);
        if (e_link >= 0) begin
            chk({tag, ":link_cycle"}, 32'(o_link), 32'(e_link));
            chk({tag, ":link_data"}, o_link_data, pc + 32'd4);
        end
        chk({tag, ":cmp_count"}, 32'(n_cmp), 32'(e_cmp));
        if (e_cmp > 0) chk({tag, ":cmp_cycle"}, 32'(o_cmp), 32'd1);
        chk({tag, ":cmp_operands"}, 32'(cmp_bad), 32'd0);
        chk({tag, ":redir_first"}, 32'(o_valid), 32'(e_valid));
        chk({tag, ":redir_len"}, 32'(n_valid), (e_valid >= 0) ? 32'(stall + 1) : 32'd0);
        chk({tag, ":redir_pc"}, 32'(pc_bad), 32'd0);
        chk({tag, ":flush_len"}, 32'(n_flush), (e_valid >= 0) ? 32'(FC) : 32'd0);
        chk({tag, ":flush_first"}, 32'(o_flush), 32'(e_flush));
        chk({tag, ":ready_back"}, 32'(o_rdy), 32'(e_rdy));
    endtask

    initial begin
        logic [1:0]  r_kind;
        logic [2:0]  r_f3;
        logic [31:0] r_pc, r_imm, r_rs1, r_rs2;
        int          r_sel, r_stall, quiet;

        bus.req_valid = 1'b0; bus.req_kind = 2'b00; bus.req_fun3 = 3'b000;
        bus.req_pc = 32'h0; bus.req_imm = 32'h0; bus.req_rs1 = 32'h0; bus.req_rs2 = 32'h0;
        bus.redir_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk_reset_outs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("beq_taken", 2'b00, 3'd0, 32'h0000_0100, 32'h0000_0020, 32'd5, 32'd5, 0);
        run_op("bne_not_taken", 2'b00, 3'd1, 32'h0000_0200, 32'h0000_0040, 32'd7, 32'd7, 0);
        run_op("jalr_clear_bit0", 2'b10, 3'd0, 32'h0000_0300, 32'h0000_0003, 32'h0000_2001, 32'h0, 1);
        run_op("jalr_misaligned", 2'b10, 3'd0, 32'h0000_0400, 32'h0000_0002, 32'h0000_2000, 32'h0, 0);
        run_op("jal_wrap_stall", 2'b01, 3'd0, 32'hFFFF_FFF0, 32'h0000_0020, 32'h0, 32'h0, 5);
        run_op("fun3_010", 2'b00, 3'd2, 32'h0000_0500, 32'h0000_0010, 32'd9, 32'd9, 0);
        run_op("kind_11", 2'b11, 3'd0, 32'h0000_0600, 32'h0000_0010, 32'd1, 32'd2, 0);
        run_op("bltu_taken", 2'b00, 3'd6, 32'h0000_0700, 32'hFFFF_FFF0, 32'd1, 32'hFFFF_FFFF, 2);
        run_op("blt_not_taken", 2'b00, 3'd4, 32'h0000_0800, 32'h0000_0010, 32'd1, 32'hFFFF_FFFF, 0);

        // Reset while a redirect is waiting on fetch.
        drive_req(2'b01, 3'd0, 32'h0000_1000, 32'h0000_0040, 32'h0, 32'h0);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("rst_redir:pre_valid", 32'(bus.redir_valid), 32'd1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outs("rst_redir");
        @(negedge clk);
        rst_n = 1'b1;
        bus.redir_ready = 1'b1;
        quiet = 0;
        repeat (4) begin
            @(posedge clk); #1;
            quiet += int'(bus.done) + int'(bus.flush) + int'(bus.redir_valid) + int'(bus.link_valid);
        end
        bus.redir_ready = 1'b0;
        chk("rst_redir:no_pulses", 32'(quiet), 32'd0);
        chk("rst_redir:ready", 32'(bus.req_ready), 32'd1);

        // Reset during the flush window.
        bus.redir_ready = 1'b1;
        drive_req(2'b00, 3'd0, 32'h0000_2000, 32'h0000_0080, 32'd3, 32'd3);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("rst_flush:pre_flush", 32'(bus.flush), 32'd1);
        bus.redir_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outs("rst_flush");
        @(negedge clk);
        rst_n = 1'b1;
        quiet = 0;
        repeat (4) begin
            @(posedge clk); #1;
            quiet += int'(bus.done) + int'(bus.flush) + int'(bus.redir_valid);
        end
        chk("rst_flush:no_pulses", 32'(quiet), 32'd0);
        chk("rst_flush:ready", 32'(bus.req_ready), 32'd1);

        for (int i = 0; i < 120; i++) begin
            r_sel = int'($urandom_range(0, 9));
            r_kind = (r_sel < 5) ? 2'b00 : (r_sel < 7) ? 2'b01 : (r_sel < 9) ? 2'b10 : 2'b11;
            r_f3 = 3'($urandom_range(0, 7));
            r_pc = $urandom & 32'hFFFF_FFFC;
            r_imm = ($urandom_range(0, 1) == 1) ? ($urandom & 32'h0000_0FFE)
                                                 : (32'hFFFF_F000 | ($urandom & 32'h0000_0FFE));
            if (r_kind == 2'b10) r_imm = r_imm | 32'($urandom_range(0, 1));
            r_rs1 = $urandom;
            case ($urandom_range(0, 2))
                0:       r_rs2 = r_rs1;
                1:       r_rs2 = r_rs1 ^ 32'h8000_0000;
                default: r_rs2 = $urandom;
            endcase
            r_stall = int'($urandom_range(0, 4));
            run_op($sformatf("rand%0d", i), r_kind, r_f3, r_pc, r_imm, r_rs1, r_rs2, r_stall);
        end

`ifdef BR_PERF_CNT_EN
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("perf:reset_taken_cnt", 32'(taken_cnt), 32'd0);
        for (int i = 0; i < 4; i++) begin
            run_op($sformatf("perf_beq%0d", i), 2'b00, 3'd0, 32'h0000_0100, 32'h0000_0020, 32'd5, 32'd5, 0);
        end
        chk("perf:taken_cnt_sat", 32'(taken_cnt), 32'd3);
        chk("perf:br_cnt_sat", 32'(br_cnt), 32'd3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
